fp_matvec_scheduler: RTL and testbench

FP_MATVEC_SCHEDULER -- requirements
Module: fp_matvec_scheduler

---
 rtl/fp_sched_pkg.sv | 25 ++
 rtl/fp_matvec_scheduler.sv | 170 +++++++++++++++++
 tb/tb_fp_matvec_scheduler.sv | 523 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_sched_pkg.sv
// Shared types for the FP32 matrix-vector scheduler.
// State encoding, FP32 word type and the ReLU helper.
package fp_sched_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP_ZERO = 32'h0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MUL_ISSUE,
    MUL_WAIT,
    ADD_ISSUE,
    ADD_WAIT,
    EMIT,
    DONE
  } state_t;

  // Any set sign bit clamps, so -0.0 also maps to +0.0.
  function automatic fp32_t relu(input fp32_t x);
    return x[31] ? FP_ZERO : x;
  endfunction

endpackage

// File: rtl/fp_matvec_scheduler.sv
// Sequences one FP32 dot product per row through external mul/add cores.
// Define SCHED_RELU_EN to clamp negative results to +0.0.
module fp_matvec_scheduler
  import fp_sched_pkg::*;
#(
  parameter int VEC_LEN = 16,
  parameter int ROWS    = 16,
  parameter int ADDR_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [31:0]       vec_data,
  output logic [ADDR_W-1:0] wgt_addr,
  input  logic [31:0]       wgt_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [31:0]       op_a,
  output logic [31:0]       op_b,
  input  logic              prod_valid,
  input  logic [31:0]       prod_data,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [31:0]       acc_a,
  output logic [31:0]       acc_b,
  input  logic              sum_valid,
  input  logic [31:0]       sum_data,
  output logic              res_valid,
  output logic [31:0]       res_data,
  output logic [7:0]        res_row
);

  localparam logic [7:0] LAST_COL = 8'(VEC_LEN - 1);
  localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);
  localparam logic [ADDR_W-1:0] STRIDE =
    ADDR_W'(VEC_LEN);

  state_t     state;
  state_t     state_n;
  logic       fetch_ph;
  logic [7:0] row;
  logic [7:0] col;
  fp32_t      vec_q;
  fp32_t      wgt_q;
  fp32_t      prod_q;
  fp32_t      acc;
  fp32_t      res_val;
  logic       last_col;
  logic       last_row;

  assign last_col = (col == LAST_COL);
  assign last_row = (row == LAST_ROW);

  assign vec_addr = ADDR_W'(col);
  assign wgt_addr = ADDR_W'(row) * STRIDE
                  + ADDR_W'(col);

  assign op_a    = vec_q;
  assign op_b    = wgt_q;
  assign acc_a   = acc;
  assign acc_b   = prod_q;
  assign res_row = row;

`ifdef SCHED_RELU_EN
  assign res_val = relu(acc);
`else
  assign res_val = acc;
`endif

  always_comb begin
    state_n   = state;
    done      = 1'b0;
    op_valid  = 1'b0;
    acc_valid = 1'b0;
    res_valid = 1'b0;
    res_data  = FP_ZERO;
    unique case (state)
      IDLE: begin
        if (start) state_n = FETCH;
      end
      FETCH: begin
        if (fetch_ph) state_n = MUL_ISSUE;
      end
      MUL_ISSUE: begin
        op_valid = 1'b1;
        if (op_ready) state_n = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (prod_valid) begin
          if (col != 8'd0)  state_n = ADD_ISSUE;
          else if (last_col) state_n = EMIT;
          else               state_n = FETCH;
        end
      end
      ADD_ISSUE: begin
        acc_valid = 1'b1;
        if (acc_ready) state_n = ADD_WAIT;
      end
      ADD_WAIT: begin
        if (sum_valid)
          state_n = last_col ? EMIT : FETCH;
      end
      EMIT: begin
        res_valid = 1'b1;
        res_data  = res_val;
        state_n   = last_row ? DONE : FETCH;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_ph <= 1'b0;
      row      <= 8'd0;
      col      <= 8'd0;
      vec_q    <= FP_ZERO;
      wgt_q    <= FP_ZERO;
      prod_q   <= FP_ZERO;
      acc      <= FP_ZERO;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start) begin
            row      <= 8'd0;
            col      <= 8'd0;
            fetch_ph <= 1'b0;
          end
        end
        // Phase 0 drives the address, phase 1 takes the read data.
        FETCH: begin
          fetch_ph <= ~fetch_ph;
          if (fetch_ph) begin
            vec_q <= vec_data;
            wgt_q <= wgt_data;
          end
        end
        MUL_WAIT: begin
          if (prod_valid) begin
            prod_q <= prod_data;
            if (col == 8'd0) begin
              acc <= prod_data;
              if (!last_col) col <= col + 8'd1;
            end
          end
        end
        ADD_WAIT: begin
          if (sum_valid) begin
            acc <= sum_data;
            if (!last_col) col <= col + 8'd1;
          end
        end
        EMIT: begin
          col <= 8'd0;
          if (!last_row) row <= row + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_matvec_scheduler.sv
// Bench for fp_matvec_scheduler: three parameter sets, behavioural
// memories and FP cores, dot products predicted with real arithmetic.
module tb_fp_matvec_scheduler;

  localparam int VLA[3] = '{16, 4, 1};
  localparam int RWA[3] = '{16, 1, 2};

  logic clk = 1'b0;
  logic reset;

  logic        start[3];
  logic        done[3];
  logic [11:0] vec_addr[3];
  logic [31:0] vec_data[3];
  logic [11:0] wgt_addr[3];
  logic [31:0] wgt_data[3];
  logic        op_valid[3];
  logic        op_ready[3];
  logic [31:0] op_a[3];
  logic [31:0] op_b[3];
  logic        prod_valid[3];
  logic [31:0] prod_data[3];
  logic        acc_valid[3];
  logic        acc_ready[3];
  logic [31:0] acc_a[3];
  logic [31:0] acc_b[3];
  logic        sum_valid[3];
  logic [31:0] sum_data[3];
  logic        res_valid[3];
  logic [31:0] res_data[3];
  logic [7:0]  res_row[3];

  logic        rdy_rnd[3];
  logic        ardy_rnd[3];
  logic        stall[3];
  int          mcnt[3];
  int          acnt[3];
  logic [31:0] mres[3];
  logic [31:0] ares[3];
  int          add_lat_force = 0;

  logic [31:0] vec_mem[3][4096];
  logic [31:0] wgt_mem[3][4096];
  int          vint[3][256];
  int          wint[3][256];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] got_d[$];
  int          got_r[$];
  int          addr_log[$];
  int          done_cnt;
  int          cyc;
  int          last_res_cyc;
  int          done_cyc;
  bit          acc_seen;

  always #5 clk = ~clk;

  fp_matvec_scheduler #(.VEC_LEN(16), .ROWS(16), .ADDR_W(12)) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .done(done[0]),
    .vec_addr(vec_addr[0]), .vec_data(vec_data[0]),
    .wgt_addr(wgt_addr[0]), .wgt_data(wgt_data[0]),
    .op_valid(op_valid[0]), .op_ready(op_ready[0]),
    .op_a(op_a[0]), .op_b(op_b[0]),
    .prod_valid(prod_valid[0]), .prod_data(prod_data[0]),
    .acc_valid(acc_valid[0]), .acc_ready(acc_ready[0]),
    .acc_a(acc_a[0]), .acc_b(acc_b[0]),
    .sum_valid(sum_valid[0]), .sum_data(sum_data[0]),
    .res_valid(res_valid[0]), .res_data(res_data[0]),
    .res_row(res_row[0])
  );

  fp_matvec_scheduler #(.VEC_LEN(4), .ROWS(1), .ADDR_W(12)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .done(done[1]),
    .vec_addr(vec_addr[1]), .vec_data(vec_data[1]),
    .wgt_addr(wgt_addr[1]), .wgt_data(wgt_data[1]),
    .op_valid(op_valid[1]), .op_ready(op_ready[1]),
    .op_a(op_a[1]), .op_b(op_b[1]),
    .prod_valid(prod_valid[1]), .prod_data(prod_data[1]),
    .acc_valid(acc_valid[1]), .acc_ready(acc_ready[1]),
    .acc_a(acc_a[1]), .acc_b(acc_b[1]),
    .sum_valid(sum_valid[1]), .sum_data(sum_data[1]),
    .res_valid(res_valid[1]), .res_data(res_data[1]),
    .res_row(res_row[1])
  );

  fp_matvec_scheduler #(.VEC_LEN(1), .ROWS(2), .ADDR_W(12)) u2 (
    .clk(clk), .reset(reset), .start(start[2]), .done(done[2]),
    .vec_addr(vec_addr[2]), .vec_data(vec_data[2]),
    .wgt_addr(wgt_addr[2]), .wgt_data(wgt_data[2]),
    .op_valid(op_valid[2]), .op_ready(op_ready[2]),
    .op_a(op_a[2]), .op_b(op_b[2]),
    .prod_valid(prod_valid[2]), .prod_data(prod_data[2]),
    .acc_valid(acc_valid[2]), .acc_ready(acc_ready[2]),
    .acc_a(acc_a[2]), .acc_b(acc_b[2]),
    .sum_valid(sum_valid[2]), .sum_data(sum_data[2]),
    .res_valid(res_valid[2]), .res_data(res_data[2]),
    .res_row(res_row[2])
  );

  function automatic real dec(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] enc(input real r);
    real    a;
    int     e;
    longint mt;
    if (r == 0.0) return 32'h0;
    a = (r < 0.0) ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    mt = longint'((a - 1.0) * 8388608.0);
    return {(r < 0.0), 8'(e), 23'(mt)};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a,
                                       input logic [31:0] b);
    return enc(dec(a) * dec(b));
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a,
                                       input logic [31:0] b);
    return enc(dec(a) + dec(b));
  endfunction

  // Reference dot product for row r of instance g.
  function automatic logic [31:0] expect_row(input int g, input int r);
    real s = 0.0;
    for (int c = 0; c < VLA[g]; c++)
      s = s + real'(vint[g][c] * wint[g][r * VLA[g] + c]);
`ifdef SCHED_RELU_EN
    if (s < 0.0) return 32'h0;
`endif
    return enc(s);
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      op_ready[i]  = rdy_rnd[i] & ~stall[i];
      acc_ready[i] = ardy_rnd[i];
    end
  end

  // Synchronous memories and fixed-latency-per-op FP cores.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      vec_data[i]   <= vec_mem[i][vec_addr[i]];
      wgt_data[i]   <= wgt_mem[i][wgt_addr[i]];
      rdy_rnd[i]    <= ($urandom_range(0, 3) != 0);
      ardy_rnd[i]   <= ($urandom_range(0, 3) != 0);
      prod_valid[i] <= (mcnt[i] == 1);
      prod_data[i]  <= mres[i];
      sum_valid[i]  <= (acnt[i] == 1);
      sum_data[i]   <= ares[i];
      if (mcnt[i] > 0) mcnt[i] <= mcnt[i] - 1;
      if (acnt[i] > 0) acnt[i] <= acnt[i] - 1;
      if (op_valid[i] && op_ready[i]) begin
        mcnt[i] <= int'($urandom_range(1, 4));
        mres[i] <= fmul(op_a[i], op_b[i]);
      end
      if (acc_valid[i] && acc_ready[i]) begin
        acnt[i] <= (add_lat_force > 0) ? add_lat_force
                                       : int'($urandom_range(1, 4));
        ares[i] <= fadd(acc_a[i], acc_b[i]);
      end
    end
  end

  task automatic set_vec(input int g, input int c, input int v);
    vint[g][c]    = v;
    vec_mem[g][c] = enc(real'(v));
  endtask

  task automatic set_wgt(input int g, input int a, input int v);
    wint[g][a]    = v;
    wgt_mem[g][a] = enc(real'(v));
  endtask

  function automatic int rnd_val();
    int m = int'($urandom_range(1, 4));
    return ($urandom_range(0, 1) != 0) ? -m : m;
  endfunction

  task automatic fill_random(input int g);
    for (int c = 0; c < VLA[g]; c++) set_vec(g, c, rnd_val());
    for (int a = 0; a < VLA[g] * RWA[g]; a++) set_wgt(g, a, rnd_val());
  endtask

  task automatic step(input int g);
    @(negedge clk);
    cyc++;
    if (res_valid[g]) begin
      got_d.push_back(res_data[g]);
      got_r.push_back(int'(res_row[g]));
      last_res_cyc = cyc;
    end
    if (done[g]) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (acc_valid[g]) acc_seen = 1'b1;
    if (op_valid[g] &&
        (addr_log.size() == 0 || addr_log[$] != int'(wgt_addr[g])))
      addr_log.push_back(int'(wgt_addr[g]));
  endtask

  task automatic kick(input int g);
    @(negedge clk);
    start[g] = 1'b1;
    got_d.delete();
    got_r.delete();
    addr_log.delete();
    done_cnt     = 0;
    cyc          = 0;
    last_res_cyc = -1;
    done_cyc     = -1;
    acc_seen     = 1'b0;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic finish_run(input int g, input int budget,
                            output bit to);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step(g);
      n++;
    end
    to = (done_cnt == 0);
    repeat (8) step(g);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if ({done[g], res_valid[g], op_valid[g], acc_valid[g]} !== 4'b0) begin
        n_bad++;
        $display("FAIL reset_ctrl[%0d]: got %b want 0000", g,
                 {done[g], res_valid[g], op_valid[g], acc_valid[g]});
      end
      n_cmp++;
      if ({vec_addr[g], wgt_addr[g], op_a[g], op_b[g], acc_a[g],
           acc_b[g], res_data[g], res_row[g]} !== '0) begin
        n_bad++;
        $display("FAIL reset_data[%0d]: addr %h/%h op %h/%h acc %h/%h res %h row %h want 0",
                 g, vec_addr[g], wgt_addr[g], op_a[g], op_b[g],
                 acc_a[g], acc_b[g], res_data[g], res_row[g]);
      end
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ones_ramp();
    bit to;
    for (int c = 0; c < 4; c++) begin
      set_vec(1, c, 1);
      set_wgt(1, c, c + 1);
    end
    kick(1);
    finish_run(1, 500, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL ramp_timeout: no done in 500 cycles"); end
    n_cmp++;
    if (got_d.size() != 1) begin
      n_bad++;
      $display("FAIL ramp_count: got %0d results want 1", got_d.size());
    end else begin
      n_cmp++;
      if (got_d[0] !== 32'h41200000 || got_r[0] != 0) begin
        n_bad++;
        $display("FAIL ramp_value: got %h row %0d want 41200000 row 0",
                 got_d[0], got_r[0]);
      end
    end
    n_cmp++;
    if (done_cnt != 1 || done_cyc <= last_res_cyc) begin
      n_bad++;
      $display("FAIL ramp_done: got %0d done at %0d (res %0d) want 1 after res",
               done_cnt, done_cyc, last_res_cyc);
    end
  endtask

  task automatic test_identity();
    bit to;
    int bad_addr = 0;
    for (int c = 0; c < 16; c++) set_vec(0, c, rnd_val());
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        set_wgt(0, r * 16 + c, (r == c) ? 1 : 0);
    kick(0);
    finish_run(0, 20000, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL ident_timeout: no done"); end
    n_cmp++;
    if (got_d.size() != 16) begin
      n_bad++;
      $display("FAIL ident_count: got %0d want 16", got_d.size());
    end else begin
      for (int r = 0; r < 16; r++) begin
        n_cmp++;
        if (got_d[r] !== vec_mem[0][r] || got_r[r] != r) begin
          n_bad++;
          $display("FAIL ident_row%0d: got %h row %0d want %h row %0d",
                   r, got_d[r], got_r[r], vec_mem[0][r], r);
        end
      end
    end
    for (int i = 0; i < addr_log.size(); i++)
      if (addr_log[i] != i) bad_addr++;
    n_cmp++;
    if (addr_log.size() != 256 || bad_addr != 0) begin
      n_bad++;
      $display("FAIL ident_addr: got %0d addrs %0d out of order want 0..255",
               addr_log.size(), bad_addr);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    for (int k = 0; k < 2; k++) begin
      fill_random(0);
      kick(0);
      if (k == 1) begin
        repeat (40) step(0);
        start[0] = 1'b1;
        step(0);
        start[0] = 1'b0;
      end
      finish_run(0, 20000, to);
      n_cmp++;
      if (to || done_cnt != 1) begin
        n_bad++;
        $display("FAIL b2b%0d_done: got %0d done timeout %0d want 1",
                 k, done_cnt, to);
      end
      n_cmp++;
      if (got_d.size() != 16) begin
        n_bad++;
        $display("FAIL b2b%0d_count: got %0d want 16", k, got_d.size());
      end else begin
        for (int r = 0; r < 16; r++) begin
          n_cmp++;
          if (got_d[r] !== expect_row(0, r) || got_r[r] != r) begin
            n_bad++;
            $display("FAIL b2b%0d_row%0d: got %h row %0d want %h row %0d",
                     k, r, got_d[r], got_r[r], expect_row(0, r), r);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    bit to;
    int n = 0;
    fill_random(1);
    kick(1);
    do begin step(1); n++; end while (!op_valid[1] && n < 20);
    n_cmp++;
    if (!op_valid[1]) begin
      n_bad++;
      $display("FAIL stall_wait: op_valid got 0 want 1 within 20 cycles");
    end
    stall[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      n_cmp++;
      if (op_valid[1] !== 1'b1 || op_a[1] !== vec_mem[1][0] ||
          op_b[1] !== wgt_mem[1][0]) begin
        n_bad++;
        $display("FAIL stall_hold%0d: got v%b %h %h want v1 %h %h", i,
                 op_valid[1], op_a[1], op_b[1], vec_mem[1][0], wgt_mem[1][0]);
      end
    end
    stall[1] = 1'b0;
    finish_run(1, 500, to);
    n_cmp++;
    if (to || got_d.size() != 1 || got_d[0] !== expect_row(1, 0)) begin
      n_bad++;
      $display("FAIL stall_result: got %0d res %h timeout %0d want 1 res %h",
               got_d.size(), (got_d.size() > 0) ? got_d[0] : 32'hx,
               to, expect_row(1, 0));
    end
  endtask

  task automatic test_mid_reset();
    bit to;
    int n = 0;
    fill_random(1);
    add_lat_force = 6;
    kick(1);
    do begin step(1); n++; end
      while (!(acc_valid[1] && acc_ready[1]) && n < 200);
    n_cmp++;
    if (!(acc_valid[1] && acc_ready[1])) begin
      n_bad++;
      $display("FAIL midrst_wait: no adder handshake in 200 cycles");
    end
    step(1);
    reset = 1'b1;
    step(1);
    step(1);
    reset = 1'b0;
    add_lat_force = 0;
    n_cmp++;
    if (done_cnt != 0 || got_d.size() != 0) begin
      n_bad++;
      $display("FAIL midrst_abort: got done %0d res %0d want 0 0",
               done_cnt, got_d.size());
    end
    fill_random(1);
    kick(1);
    finish_run(1, 500, to);
    n_cmp++;
    if (to || done_cnt != 1) begin
      n_bad++;
      $display("FAIL midrst_done: got %0d timeout %0d want 1", done_cnt, to);
    end
    n_cmp++;
    if (got_d.size() != 1 || got_d[0] !== expect_row(1, 0)) begin
      n_bad++;
      $display("FAIL midrst_value: got %0d res %h want 1 res %h",
               got_d.size(), (got_d.size() > 0) ? got_d[0] : 32'hx,
               expect_row(1, 0));
    end
  endtask

  task automatic test_negative();
    bit to;
    logic [31:0] want;
`ifdef SCHED_RELU_EN
    want = 32'h00000000;
`else
    want = 32'hC0000000;
`endif
    for (int c = 0; c < 4; c++) set_vec(1, c, 1);
    set_wgt(1, 0, -1);
    set_wgt(1, 1, -1);
    set_wgt(1, 2, 1);
    set_wgt(1, 3, -1);
    kick(1);
    finish_run(1, 500, to);
    n_cmp++;
    if (to || got_d.size() != 1 || got_d[0] !== want) begin
      n_bad++;
      $display("FAIL neg_value: got %0d res %h timeout %0d want 1 res %h",
               got_d.size(), (got_d.size() > 0) ? got_d[0] : 32'hx,
               to, want);
    end
  endtask

  task automatic test_vec1();
    bit to;
    for (int k = 0; k < 2; k++) begin
      fill_random(2);
      kick(2);
      finish_run(2, 500, to);
      n_cmp++;
      if (acc_seen) begin
        n_bad++;
        $display("FAIL vec1_adder%0d: acc_valid got 1 want 0", k);
      end
      n_cmp++;
      if (to || done_cnt != 1 || done_cyc <= last_res_cyc) begin
        n_bad++;
        $display("FAIL vec1_done%0d: got %0d timeout %0d want 1 after res",
                 k, done_cnt, to);
      end
      n_cmp++;
      if (got_d.size() != 2) begin
        n_bad++;
        $display("FAIL vec1_count%0d: got %0d want 2", k, got_d.size());
      end else begin
        for (int r = 0; r < 2; r++) begin
          n_cmp++;
          if (got_d[r] !== expect_row(2, r) || got_r[r] != r) begin
            n_bad++;
            $display("FAIL vec1_row%0d: got %h row %0d want %h row %0d",
                     r, got_d[r], got_r[r], expect_row(2, r), r);
          end
        end
      end
    end
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b0;
      stall[g] = 1'b0;
    end
    for (int g = 0; g < 3; g++)
      for (int a = 0; a < 4096; a++) begin
        vec_mem[g][a] = 32'h0;
        wgt_mem[g][a] = 32'h0;
      end
    reset = 1'b1;
    test_reset();
    test_ones_ramp();
    test_identity();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    test_negative();
    test_vec1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
